// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg -- opcodes, flag bit indices and FSM encodings for alu_seq.
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mul_seq -- iterative unsigned shift-add multiplier, one bit per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(CYCLES);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;

  // Multiplier sits in the low half and shifts out as the product shifts in.
  always_comb begin
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum, prod_q[WIDTH-1:1]};
  end

  // The final step is presented combinationally so the caller latches it on
  // the same edge that retires the multiplier.
  assign done_o    = busy_q & (cnt_q == CW'(CYCLES - 1));
  assign product_o = prod_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq -- registered ALU with NZVC flags and valid/ready handshake.
// Optional multiplier (op 13) built when ALU_MUL_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       nzvc,
  input  logic             flags_clr
);
  localparam int MSB = WIDTH - 1;

  generate
    if (MUL_CYCLES != WIDTH) begin : g_bad_mul_cycles
      $error("alu_seq: MUL_CYCLES must equal WIDTH");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nzvc_q, nzvc_d;
  logic             accept, is_mul;
  logic [WIDTH-1:0] opb, alu_res;
  logic             cin, alu_legal, alu_v, alu_c;
  logic [WIDTH:0]   add_w, sub_w;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign nzvc      = nzvc_q;

`ifdef ALU_MUL_EN
  logic               mul_done, mul_hi_nz;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   result_hi_q;

  assign is_mul    = (op == OP_MUL);
  assign mul_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];
  assign result_hi = result_hi_q;

  alu_mul_seq #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept & is_mul),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                result_hi_q <= '0;
    else if (accept)                        result_hi_q <= '0;
    else if (state_q == ST_BUSY && mul_done) result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
  end
`else
  assign is_mul    = 1'b0;
  assign result_hi = '0;
`endif

  // INC/DEC reuse the add/sub paths with b forced to 1 and no carry-in.
  always_comb begin
    opb       = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
    cin       = ((op == OP_ADC) || (op == OP_SBC)) ? nzvc_q[FLAG_C] : 1'b0;
    add_w     = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    sub_w     = {1'b0, a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
    alu_res   = '0;
    alu_legal = 1'b1;
    alu_v     = 1'b0;
    alu_c     = nzvc_q[FLAG_C];
    case (op)
      OP_ADD, OP_ADC, OP_INC: begin
        alu_res = add_w[MSB:0];
        alu_v   = (a[MSB] == opb[MSB]) & (add_w[MSB] != a[MSB]);
        if (op != OP_INC) alu_c = add_w[WIDTH];
      end
      OP_SUB, OP_SBC, OP_DEC: begin
        alu_res = sub_w[MSB:0];
        alu_v   = (a[MSB] != opb[MSB]) & (sub_w[MSB] != a[MSB]);
        if (op != OP_DEC) alu_c = sub_w[WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = {a[MSB-1:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[MSB:1]};
        alu_c   = a[0];
      end
      OP_ASR: begin
        alu_res = {a[MSB], a[MSB:1]};
        alu_c   = a[0];
      end
      default: alu_legal = 1'b0;
    endcase
  end

  // A flag write on entry to DONE takes priority over a coincident clear.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    nzvc_d   = flags_clr ? 4'b0000 : nzvc_q;
    if (accept && is_mul) begin
      state_d = ST_BUSY;
    end else if (accept) begin
      state_d  = ST_DONE;
      result_d = alu_res;
      if (alu_legal) nzvc_d = {alu_res[MSB], (alu_res == '0), alu_v, alu_c};
    end else if (state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
    end
`ifdef ALU_MUL_EN
    else if (state_q == ST_BUSY && mul_done) begin
      state_d  = ST_DONE;
      result_d = mul_prod[MSB:0];
      nzvc_d   = {mul_prod[2*WIDTH-1], (mul_prod == '0), mul_hi_nz, mul_hi_nz};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      nzvc_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      nzvc_q   <= nzvc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=8 and WIDTH=16).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_seq;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, flags_clr;
  logic [3:0]  op, nzvc;
  logic [7:0]  a, b, result, result_hi;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, flags_clr_w;
  logic [3:0]  op_w, nzvc_w;
  logic [15:0] a_w, b_w, result_w, result_hi_w;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  model_f;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .nzvc(nzvc), .flags_clr(flags_clr)
  );

  alu_seq #(.WIDTH(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .op(op_w),
    .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w),
    .result_hi(result_hi_w), .nzvc(nzvc_w), .flags_clr(flags_clr_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: integer arithmetic, overflow judged by signed range.
  function automatic void ref_op(input int w, input int o, input longint xa, input longint xb,
                                 input logic [3:0] f, output longint r, output longint hi,
                                 output logic [3:0] nf, output int lat);
    longint m, msb, sa, sb, cx, p;
    bit c, v, legal;
    m   = (longint'(1) << w) - 1;
    msb = longint'(1) << (w - 1);
    sa  = (xa >= msb) ? xa - m - 1 : xa;
    sb  = (xb >= msb) ? xb - m - 1 : xb;
    cx  = (o == 8 || o == 9) ? longint'(f[0]) : 0;
    r = 0; hi = 0; nf = f; lat = 1; c = f[0]; v = 1'b0; legal = 1'b1; p = 0;
    case (o)
      0, 8: begin
        r = (xa + xb + cx) & m; c = (xa + xb + cx) > m;
        v = ((sa + sb + cx) > msb - 1) || ((sa + sb + cx) < -msb);
      end
      1, 9: begin
        r = (xa - xb - cx) & m; c = xa < xb + cx;
        v = ((sa - sb - cx) > msb - 1) || ((sa - sb - cx) < -msb);
      end
      4: begin r = (xa + 1) & m; v = (sa + 1) > msb - 1; end
      5: begin r = (xa - 1) & m; v = (sa - 1) < -msb; end
      2: r = xa & xb;
      3: r = xa | xb;
      6: r = xa ^ xb;
      7: r = (~xa) & m;
      10: begin r = (xa * 2) & m; c = xa >= msb; end
      11: begin r = xa / 2; c = xa[0]; end
      12: begin r = xa / 2 + ((xa >= msb) ? msb : 0); c = xa[0]; end
      13: legal = MUL_EN;
      default: legal = 1'b0;
    endcase
    if (o == 13 && MUL_EN) begin
      p  = xa * xb;
      r  = p & m;
      hi = p >> w;
      lat = w + 1;
      nf = {p[2*w-1], (p == 0), (hi != 0), (hi != 0)};
    end else if (legal) begin
      nf = {(r >= msb), (r == 0), v, c};
    end
  endfunction

  // Issue one op from IDLE and wait (bounded) for out_valid; operands are
  // scrambled after accept so a design that fails to capture them is exposed.
  task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic clr, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = xa; b = xb; out_ready = 1'b0; flags_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; flags_clr = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0; op = '0; a = '0; b = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; flags_clr_w = 1'b0; op_w = '0; a_w = '0; b_w = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (result_hi !== 8'h00) begin failures++; $display("FAIL reset_result_hi got=%h exp=00", result_hi); end
    checks++; if (nzvc !== 4'b0000) begin failures++; $display("FAIL reset_nzvc got=%b exp=0000", nzvc); end
    checks++; if (in_ready_w !== 1'b1) begin failures++; $display("FAIL reset_w_in_ready got=%b exp=1", in_ready_w); end
    rst = 1'b0;
    model_f = 4'b0000;
  endtask

  task automatic test_w16;
    @(negedge clk);
    in_valid_w = 1'b1; op_w = 4'd0; a_w = 16'hFFFF; b_w = 16'h0001; out_ready_w = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_w !== 1'b1) begin failures++; $display("FAIL w16_add_valid got=%b exp=1", out_valid_w); end
    checks++; if (result_w !== 16'h0000) begin failures++; $display("FAIL w16_add_result got=%h exp=0000", result_w); end
    checks++; if (nzvc_w !== 4'b0101) begin failures++; $display("FAIL w16_add_nzvc got=%b exp=0101", nzvc_w); end
    op_w = 4'd0; a_w = 16'h7FFF; b_w = 16'h0001;
    @(negedge clk);
    checks++; if (result_w !== 16'h8000) begin failures++; $display("FAIL w16_add2_result got=%h exp=8000", result_w); end
    checks++; if (nzvc_w !== 4'b1010) begin failures++; $display("FAIL w16_add2_nzvc got=%b exp=1010", nzvc_w); end
    op_w = 4'd15; a_w = 16'h1234; b_w = 16'h5678;
    @(negedge clk);
    in_valid_w = 1'b0;
    checks++; if (result_w !== 16'h0000) begin failures++; $display("FAIL w16_illegal_result got=%h exp=0000", result_w); end
    checks++; if (nzvc_w !== 4'b1010) begin failures++; $display("FAIL w16_illegal_nzvc got=%b exp=1010", nzvc_w); end
    checks++; if (out_valid_w !== 1'b1) begin failures++; $display("FAIL w16_illegal_valid got=%b exp=1", out_valid_w); end
    @(negedge clk);
    out_ready_w = 1'b0;
  endtask

  task automatic test_directed;
    int lat;
    run_op(4'd0, 8'h7F, 8'h01, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (result !== 8'h80) begin failures++; $display("FAIL add_result got=%h exp=80", result); end
    checks++; if (nzvc !== 4'b1010) begin failures++; $display("FAIL add_nzvc got=%b exp=1010", nzvc); end
    checks++; if (result_hi !== 8'h00) begin failures++; $display("FAIL add_result_hi got=%h exp=00", result_hi); end
    retire();
    run_op(4'd1, 8'h00, 8'h01, 1'b0, lat);
    checks++; if (result !== 8'hFF) begin failures++; $display("FAIL sub_result got=%h exp=FF", result); end
    checks++; if (nzvc !== 4'b1001) begin failures++; $display("FAIL sub_nzvc got=%b exp=1001", nzvc); end
    retire();
    run_op(4'd15, 8'h55, 8'hAA, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL illegal_result got=%h exp=00", result); end
    checks++; if (nzvc !== 4'b1001) begin failures++; $display("FAIL illegal_nzvc got=%b exp=1001", nzvc); end
    retire();
    run_op(4'd8, 8'h01, 8'h01, 1'b0, lat);
    checks++; if (result !== 8'h03) begin failures++; $display("FAIL adc_result got=%h exp=03", result); end
    checks++; if (nzvc !== 4'b0000) begin failures++; $display("FAIL adc_nzvc got=%b exp=0000", nzvc); end
    retire();
    model_f = 4'b0000;
  endtask

  task automatic test_mul;
    int lat;
    run_op(4'd13, 8'h10, 8'h10, 1'b0, lat);
`ifdef ALU_MUL_EN
    checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL mul_result got=%h exp=00", result); end
    checks++; if (result_hi !== 8'h01) begin failures++; $display("FAIL mul_result_hi got=%h exp=01", result_hi); end
    checks++; if (nzvc !== 4'b0011) begin failures++; $display("FAIL mul_nzvc got=%b exp=0011", nzvc); end
    model_f = 4'b0011;
`else
    checks++; if (lat !== 1) begin failures++; $display("FAIL op13_latency got=%0d exp=1", lat); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL op13_result got=%h exp=00", result); end
    checks++; if (result_hi !== 8'h00) begin failures++; $display("FAIL op13_result_hi got=%h exp=00", result_hi); end
    checks++; if (nzvc !== model_f) begin failures++; $display("FAIL op13_nzvc got=%b exp=%b", nzvc, model_f); end
`endif
    retire();
  endtask

  task automatic test_flags_clr;
    int lat;
    run_op(4'd0, 8'h80, 8'h80, 1'b0, lat);
    checks++; if (nzvc !== 4'b0111) begin failures++; $display("FAIL clr_pre_nzvc got=%b exp=0111", nzvc); end
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    checks++; if (nzvc !== 4'b0000) begin failures++; $display("FAIL clr_hold_nzvc got=%b exp=0000", nzvc); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_hold_valid got=%b exp=1", out_valid); end
    retire();
    run_op(4'd1, 8'h00, 8'h01, 1'b1, lat);
    checks++; if (nzvc !== 4'b1001) begin failures++; $display("FAIL clr_vs_write_nzvc got=%b exp=1001", nzvc); end
    retire();
    run_op(4'd14, 8'h12, 8'h34, 1'b1, lat);
    checks++; if (nzvc !== 4'b0000) begin failures++; $display("FAIL clr_illegal_nzvc got=%b exp=0000", nzvc); end
    retire();
    model_f = 4'b0000;
  endtask

  task automatic test_backpressure;
    longint r1, h1, r2, h2;
    logic [3:0] f1, f2, o2;
    logic [7:0] xa, xb, ya, yb;
    int lat, l2;
    xa = 8'($urandom); xb = 8'($urandom);
    ref_op(8, 0, longint'(xa), longint'(xb), model_f, r1, h1, f1, l2);
    run_op(4'd0, xa, xb, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 4'd6; a = ~xa; b = xb;
      @(negedge clk);
      checks++; if (result !== r1[7:0] || nzvc !== f1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got res=%h nzvc=%b ov=%b ir=%b exp res=%h nzvc=%b ov=1 ir=0",
                 i, result, nzvc, out_valid, in_ready, r1[7:0], f1);
      end
    end
    o2 = 4'($urandom_range(2, 3)); ya = 8'($urandom); yb = 8'($urandom);
    ref_op(8, int'(o2), longint'(ya), longint'(yb), f1, r2, h2, f2, l2);
    op = o2; a = ya; b = yb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL release_valid got=%b exp=1", out_valid); end
    checks++; if (result !== r2[7:0]) begin failures++; $display("FAIL release_result got=%h exp=%h", result, r2[7:0]); end
    checks++; if (nzvc !== f2) begin failures++; $display("FAIL release_nzvc got=%b exp=%b", nzvc, f2); end
    model_f = f2;
    retire();
  endtask

  task automatic test_back_to_back;
    longint er, eh;
    logic [3:0] ef;
    int o, lat;
    logic [7:0] xa, xb;
    o = $urandom_range(0, 14); if (o == 13) o = 15;
    xa = 8'($urandom); xb = 8'($urandom);
    ref_op(8, o, longint'(xa), longint'(xb), model_f, er, eh, ef, lat);
    model_f = ef;
    @(negedge clk);
    in_valid = 1'b1; op = 4'(o); a = xa; b = xb; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== er[7:0] || nzvc !== ef) begin
        failures++;
        $display("FAIL b2b_result idx=%0d got ov=%b res=%h nzvc=%b exp ov=1 res=%h nzvc=%b",
                 i, out_valid, result, nzvc, er[7:0], ef);
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready idx=%0d got=%b exp=1", i, in_ready); end
      if (i < 11) begin
        o = $urandom_range(0, 14); if (o == 13) o = 15;
        xa = 8'($urandom); xb = 8'($urandom);
        ref_op(8, o, longint'(xa), longint'(xb), model_f, er, eh, ef, lat);
        model_f = ef;
        op = 4'(o); a = xa; b = xb;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_random;
    longint er, eh;
    logic [3:0] ef;
    int o, lat, elat;
    logic [7:0] xa, xb;
    logic clr;
    for (int i = 0; i < 60; i++) begin
      o = $urandom_range(0, 15);
      xa = 8'($urandom); xb = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      ref_op(8, o, longint'(xa), longint'(xb), model_f, er, eh, ef, elat);
      if (clr && ef == model_f && !(o <= 12 || (o == 13 && MUL_EN))) ef = 4'b0000;
      run_op(4'(o), xa, xb, clr, lat);
      checks++; if (lat !== elat) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, lat, elat); end
      checks++; if (result !== er[7:0]) begin failures++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", o, xa, xb, result, er[7:0]); end
      checks++; if (result_hi !== eh[7:0]) begin failures++; $display("FAIL rand_result_hi op=%0d got=%h exp=%h", o, result_hi, eh[7:0]); end
      checks++; if (nzvc !== ef) begin failures++; $display("FAIL rand_nzvc op=%0d a=%h b=%h clr=%b got=%b exp=%b", o, xa, xb, clr, nzvc, ef); end
      model_f = ef;
      retire();
    end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    run_op(4'd0, 8'h7F, 8'h01, 1'b0, lat);
`ifdef ALU_MUL_EN
    retire();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd13; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL busy_handshake got ir=%b ov=%b exp ir=0 ov=0", in_ready, out_valid);
    end
`endif
    #2 rst = 1'b1;
    #1;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL midrst_result got=%h exp=00", result); end
    checks++; if (result_hi !== 8'h00) begin failures++; $display("FAIL midrst_result_hi got=%h exp=00", result_hi); end
    checks++; if (nzvc !== 4'b0000) begin failures++; $display("FAIL midrst_nzvc got=%b exp=0000", nzvc); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle_valid got=%b exp=0", out_valid); end
    model_f = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_w16();
    test_directed();
    test_mul();
    test_flags_clr();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU.
- Adds an internal NZVC flag register, carry-chained ops (ADC/SBC), shifts, and an optional iterative multiplier.
- Uses a valid/ready handshake on both sides, so the control unit can stall on multi-cycle ops.
- Sits between the register file read ports and the writeback mux.

Parameters:
- WIDTH, 8, data width in bits (>=4).
- MUL_CYCLES, WIDTH, iterations of the shift-add multiplier; fixed equal to WIDTH, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept an op this cycle.
- op  input  4  operation code (see alu_pkg).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  result (low half for MUL).
- result_hi  output  WIDTH  high half of MUL product; 0 for other ops.
- nzvc  output  4  flag register: [3]N [2]Z [1]V [0]C.
- flags_clr  input  1  synchronous clear of nzvc.

Behaviour:
- Interface (decided): one clock clk; rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0.
  - result, result_hi, nzvc all 0.
  - Reset mid-MUL aborts the operation with no flag update.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept on in_valid. Single-cycle op -> DONE next cycle (latency 1). MUL -> BUSY.
  - BUSY: WIDTH cycles of shift-add, then DONE. Latency WIDTH+1 from accept. in_ready=0.
  - DONE: out_valid=1; result, result_hi and nzvc held stable.
    - On out_ready: if in_valid also high, accept the new op (back-to-back, throughput 1 for single-cycle ops); else go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Operands and op are captured at accept. Later input changes are ignored.
- Flags are written on the transition into DONE only.
  - ADC/SBC use the C value in nzvc at the accept cycle, i.e. the flags of the previous result.
- Ops (result width WIDTH, modulo 2^WIDTH):
  - ADD 0, SUB 1, AND 2, OR 3, INC 4, DEC 5, XOR 6, NOT(a) 7, ADC 8, SBC 9, SHL 10, SHR (logical) 11, ASR 12, MUL 13 (unsigned).
  - 14, 15 are illegal.
- Flag rules:
  - N = result MSB; Z = (result==0) for all legal ops except MUL.
  - ADD/ADC: C = carry out; V = a,b same sign and result sign differs.
  - SUB/SBC: C = borrow (1 when a < b + cin, unsigned); V = a,b signs differ and result sign differs from a.
  - INC/DEC: V as ADD/SUB with b=1; C unchanged.
  - Logic ops: V=0; C unchanged.
  - Shifts (by 1): C = bit shifted out; V=0.
  - MUL: N = product bit 2*WIDTH-1; Z = (full product==0); C = V = (result_hi != 0).
- Illegal op: result=0, result_hi=0, nzvc unchanged, still completes with latency 1.
- flags_clr: clears nzvc next cycle. If it coincides with a flag write, the flag write wins.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL (op 13) is supported via BUSY.
- Undefined:
  - Multiplier logic and the BUSY state are not built.
  - op 13 is treated as illegal.
  - result_hi is tied to 0.
  - All ops have latency 1.

Decomposition:
- alu_pkg holds:
  - op code localparams OP_ADD..OP_MUL;
  - flag bit indices FLAG_N/Z/V/C;
  - FSM state encodings.
- One sub-module, alu_mul_seq (start/done, WIDTH-cycle shift-add, 2*WIDTH product). Instantiated only under ALU_MUL_EN.

Test Plan:
- WIDTH=8, ADD a=7F b=01 -> one cycle after accept: result=80, nzvc=1010, out_valid=1.
- SUB a=00 b=01 -> result=FF, nzvc=1001; then ADC a=01 b=01 -> result=03 (carry-in 1), nzvc=0000.
- MUL a=10 b=10 (ALU_MUL_EN) -> out_valid exactly 9 cycles after accept: result=00, result_hi=01, nzvc=0011.
- Backpressure: out_ready low 3 cycles in DONE -> result/nzvc stable, in_ready=0. Raise out_ready with in_valid -> new op accepted that cycle.
- Assert rst during BUSY of MUL -> outputs immediately 0, nzvc=0000, in_ready=1 after release.
- WIDTH=16, ADD FFFF+0001 -> result=0000, nzvc=0101. Op 15 -> result=0000, nzvc unchanged.
